flags_ctrl: RTL and testbench

Sequences all writes to the NZCV status register and resolves B.cond conditions against settled flags. Two flag producers share the single status-register write port: the single-cycle ALU (ADDS/SUBS/ANDS) and the multicycle MDU. Writes retire strictly in decode issue order, tracked by an in-order tag FIFO. The block sits between decode, the execute units and the status register.

---
 rtl/flags_ctrl_pkg.sv | 40 ++++
 rtl/flags_ctrl_cond_eval.sv | 43 ++++
 rtl/flags_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_flags_ctrl.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flags_ctrl_pkg.sv
// flags_ctrl_pkg
// Shared constants for the NZCV flag write sequencer:
//   - ARM condition-code encodings (COND_EQ .. COND_NV)
//   - flag producer IDs carried in the in-order tag FIFO
//   - condition FSM state encoding
//   - bit positions of N, Z, C, V inside a 4-bit {N,Z,C,V} vector
package flags_ctrl_pkg;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_HS = 4'h2;
  localparam logic [3:0] COND_LO = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  localparam logic SRC_ALU = 1'b0;
  localparam logic SRC_MDU = 1'b1;

  localparam int NZCV_N = 3;
  localparam int NZCV_Z = 2;
  localparam int NZCV_C = 1;
  localparam int NZCV_V = 0;

  typedef enum logic [1:0] {
    C_IDLE = 2'd0,
    C_WAIT = 2'd1,
    C_RESP = 2'd2
  } cond_state_t;

endpackage

// File: rtl/flags_ctrl_cond_eval.sv
// flags_ctrl_cond_eval
// Purely combinational ARM condition evaluator.
// Ports:
//   nzcv  in  4  flags {N,Z,C,V}
//   cond  in  4  condition encoding
//   taken out 1  condition holds for these flags
module flags_ctrl_cond_eval
  import flags_ctrl_pkg::*;
(
  input  logic [3:0] nzcv,
  input  logic [3:0] cond,
  output logic       taken
);

  logic n, z, c, v;

  assign n = nzcv[NZCV_N];
  assign z = nzcv[NZCV_Z];
  assign c = nzcv[NZCV_C];
  assign v = nzcv[NZCV_V];

  always_comb begin
    taken = 1'b1;
    case (cond)
      COND_EQ: taken = z;
      COND_NE: taken = !z;
      COND_HS: taken = c;
      COND_LO: taken = !c;
      COND_MI: taken = n;
      COND_PL: taken = !n;
      COND_VS: taken = v;
      COND_VC: taken = !v;
      COND_HI: taken = c && !z;
      COND_LS: taken = !c || z;
      COND_GE: taken = (n == v);
      COND_LT: taken = (n != v);
      COND_GT: taken = !z && (n == v);
      COND_LE: taken = z || (n != v);
      default: taken = 1'b1;  // AL and NV
    endcase
  end

endmodule

// File: rtl/flags_ctrl.sv
// flags_ctrl
// Serialises NZCV writes from the ALU and MDU onto the single status-register
// write port in decode issue order, and resolves B.cond requests once all
// outstanding flag writes have landed.
// Optional build macro: FLAGS_CTRL_FWD_EN -- resolve a waiting condition
// directly from the flags being acked when that ack retires the last
// outstanding write, instead of waiting for the shadow register.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   issue_valid/src/ready      decode issue of a flag-setting instruction
//   alu_valid/nzcv/ack         ALU flag delivery
//   mdu_valid/nzcv/ack         MDU flag delivery
//   update_sreg, flags_out     registered status-register write port
//   cond_valid/code            B.cond request (held until cond_ready)
//   cond_ready/taken           one-cycle resolution pulse and result
//   pending                    number of outstanding flag writes
module flags_ctrl
  import flags_ctrl_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             issue_valid,
  input  logic             issue_src,
  output logic             issue_ready,
  input  logic             alu_valid,
  input  logic [3:0]       alu_nzcv,
  output logic             alu_ack,
  input  logic             mdu_valid,
  input  logic [3:0]       mdu_nzcv,
  output logic             mdu_ack,
  output logic             update_sreg,
  output logic [3:0]       flags_out,
  input  logic             cond_valid,
  input  logic [3:0]       cond_code,
  output logic             cond_ready,
  output logic             cond_taken,
  output logic [PTR_W:0]   pending
);

  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [DEPTH-1:0] tag_reg;
  logic [DEPTH-1:0] tag_wr_en;
  logic [PTR_W-1:0] head_ptr_reg, tail_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic [3:0]       shadow_reg, flags_reg;
  logic             update_reg;

  cond_state_t      state_reg, state_next;
  logic [3:0]       code_reg, code_next;
  logic             ready_reg, ready_next;
  logic             taken_reg, taken_next;

  logic             fifo_empty, head_src, push, pop;
  logic [3:0]       ack_nzcv;
  logic [3:0]       code_sel;
  logic             shadow_taken;

  // Retire: only the producer owning the head tag may be acked.
  assign fifo_empty = (count_reg == '0);
  assign head_src   = tag_reg[head_ptr_reg];
  assign alu_ack    = !fifo_empty && (head_src == SRC_ALU) && alu_valid;
  assign mdu_ack    = !fifo_empty && (head_src == SRC_MDU) && mdu_valid;
  assign pop        = alu_ack || mdu_ack;
  assign ack_nzcv   = mdu_ack ? mdu_nzcv : alu_nzcv;

  // Issue is frozen while a branch is waiting so no younger flag write can
  // slip in ahead of its resolution.
  assign issue_ready = (count_reg < CNT_FULL) && (state_reg == C_IDLE);
  assign push        = issue_valid && issue_ready;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_tag_we
    assign tag_wr_en[gi] = push && (tail_ptr_reg == PTR_W'(gi));
  end

  // Tag storage needs no reset: entries are only read while counted valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (tag_wr_en[i]) tag_reg[i] <= issue_src;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_ptr_reg <= '0;
      tail_ptr_reg <= '0;
      count_reg    <= '0;
      update_reg   <= 1'b0;
      flags_reg    <= '0;
      shadow_reg   <= '0;
    end else begin
      if (push) tail_ptr_reg <= tail_ptr_reg + PTR_ONE;
      if (pop)  head_ptr_reg <= head_ptr_reg + PTR_ONE;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_ONE;
        2'b01:   count_reg <= count_reg - CNT_ONE;
        default: count_reg <= count_reg;
      endcase
      update_reg <= pop;
      if (pop) begin
        flags_reg  <= ack_nzcv;
        shadow_reg <= ack_nzcv;
      end
    end
  end

  // In C_IDLE the request code is still on the input; afterwards it is latched.
  assign code_sel = (state_reg == C_IDLE) ? cond_code : code_reg;

  flags_ctrl_cond_eval u_eval_shadow (
    .nzcv  (shadow_reg),
    .cond  (code_sel),
    .taken (shadow_taken)
  );

`ifdef FLAGS_CTRL_FWD_EN
  logic fwd_taken;
  logic fwd_hit;

  // The last outstanding write is retiring right now: its flags are final.
  assign fwd_hit = (count_reg == CNT_ONE) && pop;

  flags_ctrl_cond_eval u_eval_fwd (
    .nzcv  (ack_nzcv),
    .cond  (code_sel),
    .taken (fwd_taken)
  );
`endif

  always_comb begin
    state_next = state_reg;
    code_next  = code_reg;
    taken_next = 1'b0;
    case (state_reg)
      C_IDLE: begin
        if (cond_valid) begin
          code_next = cond_code;
          if (fifo_empty) begin
            state_next = C_RESP;
            taken_next = shadow_taken;
`ifdef FLAGS_CTRL_FWD_EN
          end else if (fwd_hit) begin
            state_next = C_RESP;
            taken_next = fwd_taken;
`endif
          end else begin
            state_next = C_WAIT;
          end
        end
      end
      C_WAIT: begin
        if (fifo_empty) begin
          state_next = C_RESP;
          taken_next = shadow_taken;
`ifdef FLAGS_CTRL_FWD_EN
        end else if (fwd_hit) begin
          state_next = C_RESP;
          taken_next = fwd_taken;
`endif
        end
      end
      C_RESP:  state_next = C_IDLE;
      default: state_next = C_IDLE;
    endcase
    ready_next = (state_next == C_RESP);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= C_IDLE;
      code_reg  <= '0;
      ready_reg <= 1'b0;
      taken_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      code_reg  <= code_next;
      ready_reg <= ready_next;
      taken_reg <= taken_next;
    end
  end

  assign update_sreg = update_reg;
  assign flags_out   = flags_reg;
  assign cond_ready  = ready_reg;
  assign cond_taken  = taken_reg;
  assign pending     = count_reg;

endmodule

// File: tb/tb_flags_ctrl.sv
// tb_flags_ctrl
// Directed bench for flags_ctrl. Stimulus pushes expected status-register
// writes and condition results into queues; a negedge monitor pops and
// compares whenever update_sreg or cond_ready is presented.
module tb_flags_ctrl;
  import flags_ctrl_pkg::*;

  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  logic             clk;
  logic             reset;
  logic             issue_valid, issue_src, issue_ready;
  logic             alu_valid, alu_ack;
  logic [3:0]       alu_nzcv;
  logic             mdu_valid, mdu_ack;
  logic [3:0]       mdu_nzcv;
  logic             update_sreg;
  logic [3:0]       flags_out;
  logic             cond_valid, cond_ready, cond_taken;
  logic [3:0]       cond_code;
  logic [PTR_W:0]   pending;

  flags_ctrl #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .issue_valid (issue_valid),
    .issue_src   (issue_src),
    .issue_ready (issue_ready),
    .alu_valid   (alu_valid),
    .alu_nzcv    (alu_nzcv),
    .alu_ack     (alu_ack),
    .mdu_valid   (mdu_valid),
    .mdu_nzcv    (mdu_nzcv),
    .mdu_ack     (mdu_ack),
    .update_sreg (update_sreg),
    .flags_out   (flags_out),
    .cond_valid  (cond_valid),
    .cond_code   (cond_code),
    .cond_ready  (cond_ready),
    .cond_taken  (cond_taken),
    .pending     (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       taken;
    int         at_cyc;
    logic [3:0] code;
  } cond_exp_t;

  logic [3:0] flags_q [$];
  cond_exp_t  cond_q  [$];

`ifdef FLAGS_CTRL_FWD_EN
  localparam int WAIT_LAT = 1;
`else
  localparam int WAIT_LAT = 2;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_cond(input logic [3:0] code, input logic taken, input int lat);
    cond_exp_t ce;
    ce.taken  = taken;
    ce.at_cyc = cyc + lat;
    ce.code   = code;
    cond_q.push_back(ce);
  endtask

  // Starts and ends just after a rising edge with the FIFO empty.
  task automatic alu_write(input logic [3:0] f);
    issue_valid = 1'b1;
    issue_src   = SRC_ALU;
    #1 check("setup_issue_ready", issue_ready, 1);
    step();
    issue_valid = 1'b0;
    alu_valid   = 1'b1;
    alu_nzcv    = f;
    #1 check("setup_alu_ack", alu_ack, 1);
    flags_q.push_back(f);
    step();
    alu_valid = 1'b0;
  endtask

  // Condition with settled flags: resolves one cycle later.
  task automatic cond_req(input logic [3:0] code, input logic taken);
    cond_valid = 1'b1;
    cond_code  = code;
    expect_cond(code, taken, 1);
    step();
    cond_valid = 1'b0;
    step();
  endtask

  always @(negedge clk) begin : monitor
    logic [3:0] ef;
    cond_exp_t  ce;
    if (!reset) begin
      if (update_sreg) begin
        if (flags_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sreg_write: got unexpected write flags=%b required none", flags_out);
        end else begin
          ef = flags_q.pop_front();
          $display("cyc %0d sreg write flags=%b expected=%b", cyc, flags_out, ef);
          check("sreg_flags", {28'd0, flags_out}, {28'd0, ef});
        end
      end
      if (cond_ready) begin
        if (cond_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL cond_resp: got unexpected cond_ready taken=%0d required none", cond_taken);
        end else begin
          ce = cond_q.pop_front();
          $display("cyc %0d cond code=%h taken=%0d expected=%0d", cyc, ce.code, cond_taken, ce.taken);
          check("cond_taken", cond_taken, ce.taken);
          check("cond_latency", cyc, ce.at_cyc);
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int waited;
    logic got;
    reset       = 1'b1;
    issue_valid = 1'b0;
    issue_src   = SRC_ALU;
    alu_valid   = 1'b0;
    alu_nzcv    = '0;
    mdu_valid   = 1'b0;
    mdu_nzcv    = '0;
    cond_valid  = 1'b0;
    cond_code   = '0;
    #2;
    check("rst_update_sreg", update_sreg, 0);
    check("rst_flags_out",   flags_out,   0);
    check("rst_pending",     pending,     0);
    check("rst_cond_ready",  cond_ready,  0);
    check("rst_cond_taken",  cond_taken,  0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    step();
    check("rst_issue_ready", issue_ready, 1);

    // Single ALU write
    issue_valid = 1'b1;
    issue_src   = SRC_ALU;
    #1 check("t1_issue_ready", issue_ready, 1);
    step();
    issue_valid = 1'b0;
    alu_valid   = 1'b1;
    alu_nzcv    = 4'b0100;
    #1 check("t1_alu_ack", alu_ack, 1);
    check("t1_pending_1", pending, 1);
    flags_q.push_back(4'b0100);
    step();
    alu_valid = 1'b0;
    #1 check("t1_pending_0", pending, 0);
    check("t1_flags_out", flags_out, 4'b0100);

    // MDU then ALU: ordering enforced
    step();
    issue_valid = 1'b1;
    issue_src   = SRC_MDU;
    step();
    issue_src   = SRC_ALU;
    #1 check("t2_pending_1", pending, 1);
    step();
    issue_valid = 1'b0;
    alu_valid   = 1'b1;
    alu_nzcv    = 4'b1000;
    #1 check("t2_alu_blocked", alu_ack, 0);
    check("t2_pending_2", pending, 2);
    step();
    mdu_valid = 1'b1;
    mdu_nzcv  = 4'b0010;
    #1 check("t2_mdu_ack", mdu_ack, 1);
    check("t2_alu_still_blocked", alu_ack, 0);
    flags_q.push_back(4'b0010);
    step();
    mdu_valid = 1'b0;
    #1 check("t2_alu_ack", alu_ack, 1);
    flags_q.push_back(4'b1000);
    step();
    alu_valid = 1'b0;
    #1 check("t2_pending_0", pending, 0);

    // Fill, full, push+pop, pointer wrap
    for (int i = 0; i < DEPTH; i++) begin
      step();
      issue_valid = 1'b1;
      issue_src   = SRC_ALU;
      #1 check("t3_fill_ready", issue_ready, 1);
    end
    step();
    #1 check("t3_full_pending", pending, 4);
    check("t3_full_not_ready", issue_ready, 0);
    step();
    issue_valid = 1'b0;
    alu_valid   = 1'b1;
    alu_nzcv    = 4'b0001;
    #1 check("t3_pop_from_full", alu_ack, 1);
    check("t3_rejected_issue", pending, 4);
    flags_q.push_back(4'b0001);
    step();
    issue_valid = 1'b1;
    issue_src   = SRC_MDU;
    alu_nzcv    = 4'b0011;
    #1 check("t3_ready_at_3", issue_ready, 1);
    check("t3_pp_ack", alu_ack, 1);
    check("t3_pending_3", pending, 3);
    flags_q.push_back(4'b0011);
    step();
    issue_valid = 1'b0;
    alu_nzcv    = 4'b0101;
    #1 check("t3_push_pop_hold", pending, 3);
    check("t3_ack_a", alu_ack, 1);
    flags_q.push_back(4'b0101);
    step();
    alu_nzcv = 4'b0111;
    #1 check("t3_ack_b", alu_ack, 1);
    check("t3_pending_2", pending, 2);
    flags_q.push_back(4'b0111);
    step();
    alu_nzcv = 4'b0000;
    #1 check("t3_head_mdu_blocks_alu", alu_ack, 0);
    check("t3_pending_1", pending, 1);
    step();
    alu_valid = 1'b0;
    mdu_valid = 1'b1;
    mdu_nzcv  = 4'b1110;
    #1 check("t3_mdu_ack", mdu_ack, 1);
    flags_q.push_back(4'b1110);
    step();
    mdu_valid = 1'b0;
    #1 check("t3_pending_0", pending, 0);

    // Condition evaluation on settled flags
    step();
    alu_write(4'b0110);  // N=0 Z=1 C=1 V=0
    cond_req(COND_HI, 1'b0);
    cond_req(COND_LS, 1'b1);
    cond_req(COND_EQ, 1'b1);
    cond_req(COND_HS, 1'b1);
    cond_req(COND_PL, 1'b1);
    cond_req(COND_VC, 1'b1);
    alu_write(4'b0010);  // C only
    cond_req(COND_HI, 1'b1);
    cond_req(COND_LO, 1'b0);
    alu_write(4'b1001);  // N=1 V=1
    cond_req(COND_GT, 1'b1);
    cond_req(COND_LT, 1'b0);
    cond_req(COND_GE, 1'b1);
    cond_req(COND_MI, 1'b1);
    cond_req(COND_VS, 1'b1);
    cond_req(COND_NE, 1'b1);
    cond_req(COND_LE, 1'b0);
    cond_req(COND_AL, 1'b1);
    cond_req(COND_NV, 1'b1);

    // Condition waiting on an outstanding MDU write
    issue_valid = 1'b1;
    issue_src   = SRC_MDU;
    #1 check("t5_issue_ready", issue_ready, 1);
    step();
    issue_valid = 1'b0;
    cond_valid  = 1'b1;
    cond_code   = COND_EQ;
    step();
    #1 check("t5_wait_blocks_issue", issue_ready, 0);
    check("t5_no_early_ready", cond_ready, 0);
    step();
    #1 check("t5_still_waiting", cond_ready, 0);
    check("t5_pending_1", pending, 1);
    step();
    mdu_valid = 1'b1;
    mdu_nzcv  = 4'b0100;
    #1 check("t5_mdu_ack", mdu_ack, 1);
    flags_q.push_back(4'b0100);
    expect_cond(COND_EQ, 1'b1, WAIT_LAT);
    step();
    mdu_valid = 1'b0;
    got    = 1'b0;
    waited = 0;
    while (!got && waited < 6) begin
      if (cond_ready) begin
        got        = 1'b1;
        cond_valid = 1'b0;
      end else begin
        step();
        waited++;
      end
    end
    cond_valid = 1'b0;
    check("t5_resolved", got, 1);
    step();

    // Reset during C_WAIT with two writes outstanding
    step();
    issue_valid = 1'b1;
    issue_src   = SRC_ALU;
    step();
    step();
    issue_valid = 1'b0;
    cond_valid  = 1'b1;
    cond_code   = COND_NE;
    step();
    #1 check("t6_wait_not_ready", issue_ready, 0);
    check("t6_pending_2", pending, 2);
    check("t6_flags_before", flags_out, 4'b0100);
    reset = 1'b1;
    #1 check("t6_rst_update", update_sreg, 0);
    check("t6_rst_flags", flags_out, 0);
    check("t6_rst_pending", pending, 0);
    check("t6_rst_cond_ready", cond_ready, 0);
    check("t6_rst_cond_taken", cond_taken, 0);
    step();
    cond_valid = 1'b0;
    reset      = 1'b0;
    step();
    alu_valid = 1'b1;
    alu_nzcv  = 4'b1111;
    #1 check("t6_empty_alu_ignored", alu_ack, 0);
    check("t6_issue_ready", issue_ready, 1);
    step();
    alu_valid = 1'b0;
    #1 check("t6_pending_0", pending, 0);
    check("t6_no_write", update_sreg, 0);
    step();
    alu_write(4'b1010);

    repeat (3) step();
    check("flags_q_drained", flags_q.size(), 0);
    check("cond_q_drained", cond_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
